// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the MUL AB / DIV AB arithmetic unit. This package
// holds the unit's operation and FSM encodings, plus the opcodes and SFR
// addresses that surround it in the core.
// Contents:
//   OP_MUL / OP_DIV     - value of the unit's op input
//   state_e             - FSM state encoding (IDLE, RUN, DONE)
//   OPC_* / SFR_*       - instruction opcodes and SFR addresses the unit serves
//   is_div_by_zero()    - detects the divide-by-zero shortcut case
// -----------------------------------------------------------------------------
package mul_div_unit_pkg;

  // Operation select carried on op_i
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Instruction opcodes that dispatch to this unit
  localparam logic [7:0] OPC_MUL_AB = 8'hA4;
  localparam logic [7:0] OPC_DIV_AB = 8'h84;

  // SFR addresses written back when done_o pulses
  localparam logic [7:0] SFR_ACC = 8'hE0;
  localparam logic [7:0] SFR_B   = 8'hF0;
  localparam logic [7:0] SFR_PSW = 8'hD0;

  // Number of shift iterations for an 8-bit operand
  localparam int unsigned ITERATIONS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A divide with a zero divisor skips RUN and reports overflow at once
  function automatic logic is_div_by_zero(input logic op, input logic [7:0] divisor);
    return (op == OP_DIV) && (divisor == 8'h00);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// -----------------------------------------------------------------------------
// mul_div_step
// One combinational iteration of the MUL/DIV datapath. The working pair
// {hi, lo} is 16 bits wide.
//   MUL (shift-add):  hi holds the partial product, lo the remaining
//                     multiplier bits. If lo[0] is set, b is added to hi; the
//                     9-bit sum and lo are then shifted right as one value.
//   DIV (restoring):  hi holds the partial remainder, lo the dividend bits
//                     still to be consumed and the quotient bits produced so
//                     far. {hi, lo} is shifted left; if the shifted remainder
//                     is at least b, b is subtracted and a 1 is placed in the
//                     quotient.
// After 8 iterations, lo holds the MUL low byte / DIV quotient and hi holds
// the MUL high byte / DIV remainder.
// Ports:
//   op_i        - OP_MUL or OP_DIV
//   hi_i, lo_i  - current working pair
//   b_i         - multiplier / divisor
//   hi_o, lo_o  - working pair after one iteration
// -----------------------------------------------------------------------------
module mul_div_step
  import mul_div_unit_pkg::*;
(
  input  logic       op_i,
  input  logic [7:0] hi_i,
  input  logic [7:0] lo_i,
  input  logic [7:0] b_i,
  output logic [7:0] hi_o,
  output logic [7:0] lo_o
);

  logic [8:0] sum9_s;
  logic [8:0] rem9_s;
  logic [7:0] diff8_s;

  // Single shift-add or shift-subtract iteration
  always_comb begin
    sum9_s  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : 9'h000);
    rem9_s  = {hi_i, lo_i[7]};
    // Used only when rem9_s >= b_i. The true difference is then below b_i,
    // so it fits in 8 bits.
    diff8_s = rem9_s[7:0] - b_i;
    if (op_i == OP_MUL) begin
      hi_o = sum9_s[8:1];
      lo_o = {sum9_s[0], lo_i[7:1]};
    end else if (rem9_s >= {1'b0, b_i}) begin
      hi_o = diff8_s;
      lo_o = {lo_i[6:0], 1'b1};
    end else begin
      hi_o = rem9_s[7:0];
      lo_o = {lo_i[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative 8-bit unsigned multiply / divide unit for MUL AB and DIV AB.
// The FSM has three states: IDLE -> RUN (8 cycles) -> DONE (1 cycle) -> IDLE.
// A divide by zero goes from IDLE directly to DONE.
// Ports:
//   clock_i    - clock; all state changes on the rising edge
//   reset_i    - synchronous active-high reset
//   start_i    - request; sampled only in IDLE
//   op_i       - 0 = MUL, 1 = DIV
//   a_in_i     - ACC operand (multiplicand / dividend)
//   b_in_i     - B operand (multiplier / divisor)
//   busy_o     - high in RUN and DONE
//   done_o     - one-cycle result strobe for ACC/B/PSW write-back
//   a_out_o    - MUL low byte / DIV quotient
//   b_out_o    - MUL high byte / DIV remainder
//   ov_o       - PSW.OV result
//   cy_o       - PSW.CY result (always 0)
// Result outputs keep their value until the next DONE.
// -----------------------------------------------------------------------------
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       op_i,
  input  logic [7:0] a_in_i,
  input  logic [7:0] b_in_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] a_out_o,
  output logic [7:0] b_out_o,
  output logic       ov_o,
  output logic       cy_o
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] bop_q, bop_d;
  logic [7:0] a_out_q, a_out_d;
  logic [7:0] b_out_q, b_out_d;
  logic       ov_q, ov_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cy_q;
  logic [7:0] step_hi_s;
  logic [7:0] step_lo_s;

  mul_div_step u_step (
    .op_i (op_q),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .b_i  (bop_q),
    .hi_o (step_hi_s),
    .lo_o (step_lo_s)
  );

  // Next-state, datapath and result computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bop_d   = bop_q;
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          bop_d = b_in_i;
          hi_d  = 8'h00;
          lo_d  = a_in_i;
          cnt_d = 3'd0;
          if (is_div_by_zero(op_i, b_in_i)) begin
            // ACC keeps the dividend and B is cleared, so both registers
            // receive a defined value.
            state_d = ST_DONE;
            a_out_d = a_in_i;
            b_out_d = 8'h00;
            ov_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        hi_d  = step_hi_s;
        lo_d  = step_lo_s;
        cnt_d = cnt_q + 3'd1;
        // The last iteration wraps the counter and publishes its result
        // on the same edge.
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
          a_out_d = step_lo_s;
          b_out_d = step_hi_s;
          ov_d    = (op_q == OP_MUL) ? (step_hi_s != 8'h00) : 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and result registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      op_q    <= OP_MUL;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      bop_q   <= 8'h00;
      a_out_q <= 8'h00;
      b_out_q <= 8'h00;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bop_q   <= bop_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cy_q    <= 1'b0;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign a_out_o = a_out_q;
  assign b_out_o = b_out_q;
  assign ov_o    = ov_q;
  assign cy_o    = cy_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: none; widths are fixed at 8-bit operands and a 16-bit internal product.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  0 = MUL AB, 1 = DIV AB.
REQ-006 a_in  input  8  ACC operand (multiplicand / dividend).
REQ-007 b_in  input  8  B operand (multiplier / divisor).
REQ-008 busy  output  1  high while the operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results valid; used directly as the ACC and B SFR write strobe.
REQ-010 a_out  output  8  MUL low byte / DIV quotient.
REQ-011 b_out  output  8  MUL high byte / DIV remainder; feeds the B SFR data_in.
REQ-012 ov  output  1  PSW.OV result.
REQ-013 cy  output  1  PSW.CY result; always 0.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at edge T, the unit SHALL latch a_in, b_in and op, clear the iteration counter, and enter RUN; DIV with b_in=0 SHALL enter DONE directly.
REQ-016 RUN SHALL last exactly 8 cycles (counter 0..7, one bit per cycle), then enter DONE; counter wrap 7->0 coincides with the RUN->DONE transition.
REQ-017 DONE SHALL last 1 cycle with done=1, then return to IDLE; latency is start-sample edge to done = 9 cycles normally, 1 cycle for divide-by-zero.
REQ-018 MUL SHALL use iterative shift-add: {b_out,a_out} = a*b, unsigned, 16 bits, no truncation; ov=1 iff the product > 0xFF.
REQ-019 DIV SHALL use restoring shift-subtract: a_out = floor(a/b), b_out = a mod b, unsigned; ov=0.
REQ-020 For DIV with b=0: ov=1, a_out=latched a_in, b_out=0x00 (B and ACC are rewritten with defined values).
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no queuing; start in the same cycle done=1 is also ignored.
REQ-023 a_in and b_in changes after latching SHALL NOT affect the result.
REQ-024 a_out, b_out, ov and cy SHALL hold their last result in IDLE until the next DONE.
REQ-025 Operands 0x00 and 0xFF SHALL produce exact results (0xFF*0xFF = 0xFE01; 0xFF/0x01 = 0xFF r 0x00).

Reset
REQ-026 When reset=1 at a clock edge, the unit SHALL enter IDLE; busy, done, ov and cy SHALL be 0; a_out and b_out SHALL be 0x00; the counter and operand registers SHALL be cleared.
REQ-027 Reset SHALL take priority over all other inputs, including mid-RUN and in DONE. An operation aborted by reset SHALL produce no done pulse.

Structure
REQ-028 The OP_MUL/OP_DIV encodings and FSM state encodings SHALL live in the shared define file alongside the opcode and SFR definitions.
REQ-029 One combinational sub-module, mul_div_step, SHALL compute a single shift-add or shift-subtract iteration. The FSM, counter and registers SHALL stay in mul_div_unit.

Verification
REQ-030 MUL 0x50 * 0xA0 -> done exactly 9 cycles after start; a_out=0x00, b_out=0x32, ov=1, cy=0.
REQ-031 MUL 0x0C * 0x0A -> a_out=0x78, b_out=0x00, ov=0; also 0xFF*0xFF -> a_out=0x01, b_out=0xFE, ov=1.
REQ-032 DIV 0xFB / 0x12 -> a_out=0x0D, b_out=0x11, ov=0, done at cycle 9; also 0x05 / 0x07 -> a_out=0x00, b_out=0x05.
REQ-033 DIV 0x42 / 0x00 -> done 1 cycle after start; ov=1, a_out=0x42, b_out=0x00.
REQ-034 Start MUL, pulse start again with new operands at cycles 3 and 9, then assert reset at cycle 4 of a second run -> first result unaffected by the extra starts; after reset busy=0, outputs 0x00, and no done pulse.
